mask_row_serializer: RTL and testbench
======================================

# mask_row_serializer

Downstream stage of `mask_generation`. Accepts one full mask row (`mg_mask`, qualified by `rp_valid`) per event, buffers up to two rows, and streams each row to the image-sensor pixel-mask interface as `serialWidth`-bit beats under a valid/ready handshake. Tracks row position within the frame for the selected `imageSensorResolution` and flags row start, frame end and buffer overflow.

## Interface
- `maxImageSensorCols`, 64, columns in a full-resolution mask row; must be a multiple of 8*`serialWidth`
- `maxImageSensorRows`, 64, rows per frame at full resolution; multiple of 8
- `serialWidth`, 8, bits per output beat
- `clk` in 1 system clock; all logic on rising edge
- `rst_n` in 1 asynchronous, active-low reset
- `clk_en` in 1 clock enable; low freezes all state and outputs
- `imageSensorResolution` in 2 00 full, 01 half, 10 quarter, 11 eighth (cols and rows scaled)
- `mg_mask` in [0:maxImageSensorCols-1] mask row from `mask_generation`; index 0 = column 0
- `rp_valid` in 1 `mg_mask` valid this cycle
- `ms_ready` out 1 buffer has a free slot (count < 2)
- `ms_data` out serialWidth beat; `ms_data[k]` = column beat*serialWidth+k
- `ms_valid` out 1 `ms_data` valid
- `ms_ready_in` in 1 sensor accepts beat
- `ms_row_start` out 1 high with first beat of each row
- `ms_frame_end` out 1 high with last beat of last row of frame
- `ms_row_idx` out clog2(maxImageSensorRows) row currently being sent
- `ms_overflow` out 1 sticky: a valid row was dropped

## Operation
- Active columns C = maxImageSensorCols >> res; beats per row B = C/serialWidth; active rows R = maxImageSensorRows >> res. Only `mg_mask[0:C-1]` is stored/sent.
- Row buffer: 2-entry FIFO (wr_ptr, rd_ptr, count 0..2).
- Write: on `clk_en && rp_valid`; accepted if count<2, or count==2 and the last beat of the head row pops in the same cycle. Otherwise row dropped, `ms_overflow` set (cleared only by reset).
- FSM IDLE / SEND:
  - IDLE: count>0 -> SEND, beat=0, `ms_valid`=1 next cycle.
  - SEND: beat transfers when `ms_valid && ms_ready_in && clk_en`; beat++; at beat==B-1 transfer: pop FIFO, row_idx++; if row_idx==R-1 -> row_idx=0 and `ms_frame_end` with that beat. If FIFO non-empty after pop (incl. same-cycle write), stay SEND with beat=0, no bubble; else IDLE.
- Resolution latched into internal res_q only when row_idx==0 and FSM enters/continues to beat 0 of a new row; mid-frame changes ignored until frame wrap.
- `ms_data`, `ms_row_start` stable while `ms_valid && !ms_ready_in`.

## Timing
- Reset values: `ms_valid`=0, `ms_data`=0, `ms_row_start`=0, `ms_frame_end`=0, `ms_row_idx`=0, `ms_overflow`=0, `ms_ready`=1, FIFO empty, FSM IDLE, res_q=00.
- Latency: row written at edge t (buffer empty, IDLE) -> first beat valid after edge t+1. Back-to-back rows: no idle cycle between last beat of row n and first beat of row n+1.
- Throughput with `ms_ready_in`=1: one beat per cycle; one row per B cycles.
- `ms_ready` registered from count; reflects count after each edge.
- `clk_en`=0: no write, no beat transfer, all registers hold (`rp_valid` ignored).
- Reset asserted mid-row: immediate clear of FIFO, FSM, outputs; partial row discarded.
- `ms_frame_end` and `ms_row_start` are both high for the single beat when B=1 and it is the last row.

## Test plan
- Reset, res=00, one row 0xF0000000_0000000F... (cols 0-3 and 60-63 = 1), `ms_ready_in`=1 -> 8 beats, beat0 `ms_data`=0x0F, beat7=0xF0, `ms_row_start` on beat0 only, first valid one cycle after write.
- res=11 (C=8, B=1, R=8): 8 rows -> 8 single beats, `ms_row_idx` 0..7, `ms_frame_end` on 8th with `ms_row_start` also high, idx wraps to 0.
- Three consecutive `rp_valid` with `ms_ready_in`=0 -> first two buffered, `ms_ready`=0 after second, third dropped, `ms_overflow`=1 and stays 1.
- Count==2, write coincident with last-beat pop (res=11) -> write accepted, no overflow, next row sent with no bubble.
- Random `ms_ready_in` stalls, res=01 (B=4) -> `ms_data` held during stalls; scoreboard matches columns 0-31 of each row in order.
- Change `imageSensorResolution` 00->10 at row 5 -> beats stay 8/row until frame end, then 2/row with R=16.

Source files
------------

// File: rtl/mask_row_serializer.sv
// rtl/mask_row_serializer.sv - two-row mask buffer streaming rows as serial beats to the sensor
module mask_row_serializer #(
    parameter int maxImageSensorCols = 64,
    parameter int maxImageSensorRows = 64,
    parameter int serialWidth        = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clk_en,
    input  logic [1:0]                            imageSensorResolution,
    input  logic [0:maxImageSensorCols-1]         mg_mask,
    input  logic                                  rp_valid,
    output logic                                  ms_ready,
    output logic [serialWidth-1:0]                ms_data,
    output logic                                  ms_valid,
    input  logic                                  ms_ready_in,
    output logic                                  ms_row_start,
    output logic                                  ms_frame_end,
    output logic [$clog2(maxImageSensorRows)-1:0] ms_row_idx,
    output logic                                  ms_overflow
);

    localparam int MAX_BEATS = maxImageSensorCols / serialWidth;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int ROW_W     = $clog2(maxImageSensorRows);
    localparam int COL_W     = $clog2(maxImageSensorCols);

    typedef logic [BEAT_W:0] beat_cnt_t;
    typedef logic [ROW_W:0]  row_cnt_t;

    localparam beat_cnt_t BEATS_FULL = beat_cnt_t'(MAX_BEATS);
    localparam row_cnt_t  ROWS_FULL  = row_cnt_t'(maxImageSensorRows);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [ROW_W-1:0]              row_idx_q, row_idx_d;
    logic [1:0]                    res_q, res_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic [1:0]                    count_q, count_d;
    logic                          overflow_q, overflow_d;
    logic                          ready_q, ready_d;
    logic [maxImageSensorCols-1:0] row_mem_q [2];

    logic [maxImageSensorCols-1:0] row_in;
    logic [maxImageSensorCols-1:0] head_row;
    logic [COL_W-1:0]              bit_off;
    beat_cnt_t                     beats_last;
    row_cnt_t                      rows_last;
    logic                          sending;
    logic                          last_beat;
    logic                          last_row;
    logic                          xfer;
    logic                          pop;
    logic                          wr_accept;
    logic                          wr_drop;

    // Repack the column-ordered input so bit k of the stored row is column k.
    always_comb begin
        row_in = '0;
        for (int k = 0; k < maxImageSensorCols; k++) begin
            row_in[k] = mg_mask[k];
        end
    end

    // Row geometry for the latched resolution and the beat/pop/write qualifiers.
    always_comb begin
        beats_last = (BEATS_FULL >> res_q) - beat_cnt_t'(1);
        rows_last  = (ROWS_FULL >> res_q) - row_cnt_t'(1);
        sending    = (state_q == SEND);
        last_beat  = ({1'b0, beat_q} == beats_last);
        last_row   = ({1'b0, row_idx_q} == rows_last);
        xfer       = sending && ms_ready_in && clk_en;
        pop        = xfer && last_beat;
        // A full buffer still takes a row when the head row leaves on this same edge.
        wr_accept  = clk_en && rp_valid && ((count_q != 2'd2) || pop);
        wr_drop    = clk_en && rp_valid && !wr_accept;
    end

    // FIFO pointer, occupancy, ready and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q ^ wr_accept;
        rd_ptr_d   = rd_ptr_q ^ pop;
        count_d    = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        ready_d    = (count_d != 2'd2);
        overflow_d = overflow_q | wr_drop;
    end

    // Beat/row sequencing; resolution is only resampled when a frame begins.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        row_idx_d = row_idx_q;
        res_d     = res_q;
        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    state_d = SEND;
                    beat_d  = '0;
                    if (row_idx_q == '0) begin
                        res_d = imageSensorResolution;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_beat) begin
                        beat_d    = '0;
                        row_idx_d = last_row ? '0 : row_idx_q + 1'b1;
                        if (count_d != 2'd0) begin
                            state_d = SEND;
                            if (last_row) begin
                                res_d = imageSensorResolution;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers; clk_en low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            row_idx_q  <= '0;
            res_q      <= 2'b00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b1;
        end else if (clk_en) begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            row_idx_q  <= row_idx_d;
            res_q      <= res_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ready_q    <= ready_d;
        end
    end

    // Row storage; occupancy is tracked by count_q so the array needs no reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            row_mem_q[wr_ptr_q] <= row_in;
        end
    end

    // Beat selection from the head row; outputs derive only from registers so they hold during stalls.
    always_comb begin
        head_row     = row_mem_q[rd_ptr_q];
        bit_off      = COL_W'(beat_q * serialWidth);
        ms_valid     = sending;
        ms_data      = sending ? head_row[bit_off +: serialWidth] : '0;
        ms_row_start = sending && (beat_q == '0);
        ms_frame_end = sending && last_beat && last_row;
        ms_row_idx   = row_idx_q;
        ms_overflow  = overflow_q;
        ms_ready     = ready_q;
    end

endmodule

// File: tb/tb_mask_row_serializer.sv
// tb/tb_mask_row_serializer.sv - directed self-checking bench for mask_row_serializer
module tb_mask_row_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [1:0]  imageSensorResolution;
    logic [0:63] mg_mask;
    logic        rp_valid;
    logic        ms_ready;
    logic [7:0]  ms_data;
    logic        ms_valid;
    logic        ms_ready_in;
    logic        ms_row_start;
    logic        ms_frame_end;
    logic [5:0]  ms_row_idx;
    logic        ms_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    mask_row_serializer #(
        .maxImageSensorCols(64),
        .maxImageSensorRows(64),
        .serialWidth(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .imageSensorResolution(imageSensorResolution),
        .mg_mask(mg_mask),
        .rp_valid(rp_valid),
        .ms_ready(ms_ready),
        .ms_data(ms_data),
        .ms_valid(ms_valid),
        .ms_ready_in(ms_ready_in),
        .ms_row_start(ms_row_start),
        .ms_frame_end(ms_frame_end),
        .ms_row_idx(ms_row_idx),
        .ms_overflow(ms_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // cols bit k is column k
    task automatic set_row(input logic [63:0] cols);
        for (int k = 0; k < 64; k++) mg_mask[k] = cols[k];
    endtask

    function automatic logic [63:0] row_pat(input int i);
        logic [7:0] b;
        b = 8'(i * 37 + 5);
        return {8{b}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        clk_en = 1'b1;
        rp_valid = 1'b0;
        ms_ready_in = 1'b0;
        imageSensorResolution = 2'b00;
        mg_mask = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        n_tests++; if (ms_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", ms_valid); end
        n_tests++; if (ms_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", ms_data); end
        n_tests++; if (ms_row_start !== 1'b0) begin n_fail++; $display("FAIL reset_row_start: got %0b exp 0", ms_row_start); end
        n_tests++; if (ms_frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_frame_end: got %0b exp 0", ms_frame_end); end
        n_tests++; if (ms_row_idx !== 6'd0) begin n_fail++; $display("FAIL reset_row_idx: got %0d exp 0", ms_row_idx); end
        n_tests++; if (ms_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b exp 0", ms_overflow); end
        n_tests++; if (ms_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b exp 1", ms_ready); end
    endtask

    task automatic test_single_row;
        logic [7:0] exp_b [8];
        exp_b = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        do_reset;
        ms_ready_in = 1'b1;
        mg_mask = 64'hF000_0000_0000_000F;
        rp_valid = 1'b1;
        tick;
        rp_valid = 1'b0;
        n_tests++; if (ms_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: valid got %0b exp 0 one edge after write", ms_valid); end
        tick;
        for (int j = 0; j < 8; j++) begin
            n_tests++;
            if (ms_valid !== 1'b1 || ms_data !== exp_b[j] || ms_row_start !== (j == 0) || ms_frame_end !== 1'b0) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%0b d=%h rs=%0b fe=%0b exp v=1 d=%h rs=%0b fe=0",
                         j, ms_valid, ms_data, ms_row_start, ms_frame_end, exp_b[j], (j == 0));
            end
            tick;
        end
        n_tests++; if (ms_valid !== 1'b0 || ms_row_idx !== 6'd1) begin n_fail++; $display("FAIL single_end: got v=%0b idx=%0d exp v=0 idx=1", ms_valid, ms_row_idx); end
    endtask

    task automatic test_frame_eighth;
        logic [63:0] r;
        do_reset;
        imageSensorResolution = 2'b11;
        ms_ready_in = 1'b1;
        set_row(row_pat(20));
        rp_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k >= 2 && k <= 9) begin
                r = row_pat(20 + k - 2);
                n_tests++;
                if (ms_valid !== 1'b1 || ms_data !== r[7:0] || ms_row_idx !== 6'(k - 2) ||
                    ms_row_start !== 1'b1 || ms_frame_end !== (k == 9)) begin
                    n_fail++;
                    $display("FAIL eighth_row%0d: got v=%0b d=%h idx=%0d rs=%0b fe=%0b exp v=1 d=%h idx=%0d rs=1 fe=%0b",
                             k - 2, ms_valid, ms_data, ms_row_idx, ms_row_start, ms_frame_end, r[7:0], k - 2, (k == 9));
                end
            end
            rp_valid = (k < 8);
            set_row(row_pat(20 + k));
        end
        rp_valid = 1'b0;
        n_tests++; if (ms_valid !== 1'b0 || ms_row_idx !== 6'd0 || ms_overflow !== 1'b0) begin n_fail++; $display("FAIL eighth_wrap: got v=%0b idx=%0d ovf=%0b exp v=0 idx=0 ovf=0", ms_valid, ms_row_idx, ms_overflow); end
    endtask

    task automatic test_overflow;
        logic [63:0] ra, rb, r;
        ra = row_pat(1);
        rb = row_pat(2);
        do_reset;
        set_row(ra); rp_valid = 1'b1; tick;
        n_tests++; if (ms_ready !== 1'b1 || ms_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_first: got rdy=%0b ovf=%0b exp rdy=1 ovf=0", ms_ready, ms_overflow); end
        set_row(rb); tick;
        n_tests++; if (ms_ready !== 1'b0 || ms_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_second: got rdy=%0b ovf=%0b exp rdy=0 ovf=0", ms_ready, ms_overflow); end
        set_row(row_pat(3)); tick;
        rp_valid = 1'b0;
        n_tests++; if (ms_ready !== 1'b0 || ms_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_third: got rdy=%0b ovf=%0b exp rdy=0 ovf=1", ms_ready, ms_overflow); end
        n_tests++; if (ms_valid !== 1'b1 || ms_data !== ra[7:0]) begin n_fail++; $display("FAIL ovf_stall_head: got v=%0b d=%h exp v=1 d=%h", ms_valid, ms_data, ra[7:0]); end
        ms_ready_in = 1'b1;
        for (int j = 0; j < 16; j++) begin
            r = (j < 8) ? ra : rb;
            n_tests++;
            if (ms_valid !== 1'b1 || ms_data !== r[(j % 8) * 8 +: 8] || ms_overflow !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got v=%0b d=%h ovf=%0b exp v=1 d=%h ovf=1", j, ms_valid, ms_data, ms_overflow, r[(j % 8) * 8 +: 8]);
            end
            tick;
        end
        n_tests++; if (ms_valid !== 1'b0 || ms_overflow !== 1'b1 || ms_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got v=%0b ovf=%0b rdy=%0b exp v=0 ovf=1 rdy=1", ms_valid, ms_overflow, ms_ready); end
    endtask

    task automatic test_coincident;
        logic [63:0] r1, r2;
        r1 = row_pat(41);
        r2 = row_pat(42);
        do_reset;
        imageSensorResolution = 2'b11;
        set_row(row_pat(40)); rp_valid = 1'b1; tick;
        set_row(r1); tick;
        n_tests++; if (ms_ready !== 1'b0 || ms_valid !== 1'b1) begin n_fail++; $display("FAIL coin_full: got rdy=%0b v=%0b exp rdy=0 v=1", ms_ready, ms_valid); end
        set_row(r2); ms_ready_in = 1'b1; tick;
        rp_valid = 1'b0;
        n_tests++;
        if (ms_overflow !== 1'b0 || ms_valid !== 1'b1 || ms_data !== r1[7:0] || ms_row_idx !== 6'd1 || ms_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL coin_accept: got ovf=%0b v=%0b d=%h idx=%0d rdy=%0b exp ovf=0 v=1 d=%h idx=1 rdy=0", ms_overflow, ms_valid, ms_data, ms_row_idx, ms_ready, r1[7:0]);
        end
        tick;
        n_tests++; if (ms_valid !== 1'b1 || ms_data !== r2[7:0] || ms_row_idx !== 6'd2) begin n_fail++; $display("FAIL coin_next: got v=%0b d=%h idx=%0d exp v=1 d=%h idx=2", ms_valid, ms_data, ms_row_idx, r2[7:0]); end
        tick;
        n_tests++; if (ms_valid !== 1'b0 || ms_overflow !== 1'b0) begin n_fail++; $display("FAIL coin_end: got v=%0b ovf=%0b exp v=0 ovf=0", ms_valid, ms_overflow); end
    endtask

    task automatic test_clk_en;
        logic [63:0] r0;
        r0 = row_pat(50);
        do_reset;
        imageSensorResolution = 2'b11;
        ms_ready_in = 1'b1;
        set_row(r0); rp_valid = 1'b1; tick;
        clk_en = 1'b0;
        set_row(row_pat(51));
        for (int j = 0; j < 3; j++) begin
            tick;
            n_tests++; if (ms_valid !== 1'b0 || ms_ready !== 1'b1) begin n_fail++; $display("FAIL clken_freeze%0d: got v=%0b rdy=%0b exp v=0 rdy=1", j, ms_valid, ms_ready); end
        end
        clk_en = 1'b1; rp_valid = 1'b0; tick;
        n_tests++; if (ms_valid !== 1'b1 || ms_data !== r0[7:0]) begin n_fail++; $display("FAIL clken_resume: got v=%0b d=%h exp v=1 d=%h", ms_valid, ms_data, r0[7:0]); end
        tick;
        n_tests++; if (ms_valid !== 1'b0) begin n_fail++; $display("FAIL clken_nowrite: got v=%0b exp 0", ms_valid); end
    endtask

    task automatic test_stalls;
        logic [7:0]  exp_q [$];
        logic [7:0]  exp_b;
        logic [7:0]  held_d;
        logic        held_v;
        logic [63:0] r;
        logic [15:0] stall_pat;
        int rows_w, beats_got, cyc;
        stall_pat = 16'b1011_0010_1110_0101;
        rows_w = 0; beats_got = 0; cyc = 0; held_v = 1'b0; held_d = '0;
        do_reset;
        imageSensorResolution = 2'b01;
        while (beats_got < 24 && cyc < 500) begin
            if (held_v) begin
                n_tests++;
                if (ms_valid !== 1'b1 || ms_data !== held_d) begin n_fail++; $display("FAIL stall_hold: got v=%0b d=%h exp v=1 d=%h", ms_valid, ms_data, held_d); end
            end
            rp_valid = 1'b0;
            if (ms_ready && rows_w < 6) begin
                r = row_pat(60 + rows_w);
                set_row(r);
                rp_valid = 1'b1;
                for (int j = 0; j < 4; j++) exp_q.push_back(r[j * 8 +: 8]);
                rows_w++;
            end
            ms_ready_in = stall_pat[cyc % 16];
            if (ms_valid && ms_ready_in) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_tests++;
                if (ms_data !== exp_b) begin n_fail++; $display("FAIL stall_beat%0d: got %h exp %h", beats_got, ms_data, exp_b); end
                beats_got++;
                held_v = 1'b0;
            end else begin
                held_v = ms_valid;
                held_d = ms_data;
            end
            tick;
            cyc++;
        end
        rp_valid = 1'b0;
        ms_ready_in = 1'b1;
        n_tests++; if (beats_got != 24) begin n_fail++; $display("FAIL stall_count: got %0d beats exp 24", beats_got); end
        n_tests++; if (ms_overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %0b exp 0", ms_overflow); end
    endtask

    task automatic test_res_change;
        int beat_cnt [80];
        int idx_at [80];
        int fe_rows [$];
        int rows_w, row_no, cyc, bad8, bad2;
        logic switched;
        for (int i = 0; i < 80; i++) begin beat_cnt[i] = 0; idx_at[i] = -1; end
        rows_w = 0; row_no = -1; cyc = 0; switched = 1'b0;
        do_reset;
        ms_ready_in = 1'b1;
        while (fe_rows.size() < 2 && cyc < 2000) begin
            if (ms_valid) begin
                if (ms_row_start) begin
                    row_no++;
                    if (row_no < 80) idx_at[row_no] = int'(ms_row_idx);
                end
                if (row_no >= 0 && row_no < 80) beat_cnt[row_no]++;
                if (ms_frame_end) fe_rows.push_back(row_no);
            end
            if (!switched && ms_valid && ms_row_idx == 6'd5) begin
                imageSensorResolution = 2'b10;
                switched = 1'b1;
            end
            rp_valid = 1'b0;
            if (ms_ready && rows_w < 80) begin
                set_row(row_pat(rows_w));
                rp_valid = 1'b1;
                rows_w++;
            end
            tick;
            cyc++;
        end
        rp_valid = 1'b0;
        bad8 = 0; bad2 = 0;
        for (int i = 0; i < 64; i++) if (beat_cnt[i] != 8) bad8++;
        for (int i = 64; i < 80; i++) if (beat_cnt[i] != 2) bad2++;
        n_tests++; if (fe_rows.size() != 2) begin n_fail++; $display("FAIL res_frame_ends: got %0d frame ends exp 2", fe_rows.size()); end
        n_tests++; if (fe_rows.size() > 0 && fe_rows[0] != 63) begin n_fail++; $display("FAIL res_fe_full: got row %0d exp 63", fe_rows[0]); end
        n_tests++; if (fe_rows.size() > 1 && fe_rows[1] != 79) begin n_fail++; $display("FAIL res_fe_quarter: got row %0d exp 79", fe_rows[1]); end
        n_tests++; if (bad8 != 0) begin n_fail++; $display("FAIL res_full_beats: got %0d rows not 8 beats exp 0", bad8); end
        n_tests++; if (bad2 != 0) begin n_fail++; $display("FAIL res_quarter_beats: got %0d rows not 2 beats exp 0", bad2); end
        n_tests++; if (idx_at[64] != 0 || idx_at[79] != 15) begin n_fail++; $display("FAIL res_row_idx: got %0d/%0d exp 0/15", idx_at[64], idx_at[79]); end
    endtask

    task automatic test_reset_mid_row;
        do_reset;
        ms_ready_in = 1'b1;
        set_row(row_pat(70)); rp_valid = 1'b1; tick;
        set_row(row_pat(71)); tick;
        rp_valid = 1'b0;
        tick; tick;
        rst_n = 1'b0;
        #1;
        n_tests++; if (ms_valid !== 1'b0 || ms_data !== 8'h00 || ms_row_idx !== 6'd0 || ms_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_clear: got v=%0b d=%h idx=%0d rdy=%0b exp v=0 d=00 idx=0 rdy=1", ms_valid, ms_data, ms_row_idx, ms_ready); end
        tick;
        rst_n = 1'b1;
        tick; tick;
        n_tests++; if (ms_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got v=%0b exp 0", ms_valid); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_row;
        test_frame_eighth;
        test_overflow;
        test_coincident;
        test_clk_en;
        test_stalls;
        test_res_change;
        test_reset_mid_row;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
